// File: rtl/if_id_pipe_stage.sv
// if_id_pipe_stage: IF/ID pipeline register with valid/ready handshake, flush and optional skid buffer
module if_id_pipe_stage #(
  parameter int PC_W = 32,
  parameter int INST_W = 32,
  parameter int SKID = 1,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}},
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pcIn,
  input  logic [INST_W-1:0] instIn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [PC_W-1:0]   pcOut,
  output logic [INST_W-1:0] instOut,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};
  logic              main_valid, skid_valid, acc, iss;
  logic [PC_W-1:0]   main_pc, skid_pc;
  logic [INST_W-1:0] main_inst, skid_inst;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        drop;
  logic [CNT_W+1:0]  sum;
  // with a skid buffer, ready depends only on stored state, never on out_ready
  assign in_ready  = (SKID != 0) ? !skid_valid : (!main_valid | out_ready);
  assign acc       = in_valid & in_ready;
  assign iss       = main_valid & out_ready;
  assign drop      = {1'b0, main_valid & !iss} + {1'b0, skid_valid} + {1'b0, acc};
  assign sum       = {2'b00, cnt} + (CNT_W+2)'(drop);
  assign cnt_nxt   = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  assign out_valid = main_valid;
  assign pcOut     = main_valid ? main_pc : '0;
  assign instOut   = main_valid ? main_inst : NOP_INST;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign flush_cnt = cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pc    <= '0;
      main_inst  <= NOP_INST;
      skid_pc    <= '0;
      skid_inst  <= NOP_INST;
      cnt        <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      cnt        <= cnt_nxt;
    end else if (!main_valid || iss) begin
      main_valid <= skid_valid | acc;
      main_pc    <= skid_valid ? skid_pc : pcIn;
      main_inst  <= skid_valid ? skid_inst : instIn;
      skid_valid <= 1'b0;
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_pc    <= pcIn;
      skid_inst  <= instIn;
    end
  end
endmodule

// File: tb/tb_if_id_pipe_stage.sv
// tb_if_id_pipe_stage: directed checks of the IF/ID stage in skid, no-skid and narrow-counter builds
module tb_if_id_pipe_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b1, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] pc_in = '0, inst_in = '0;
  logic        a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
  logic [31:0] a_pc, a_inst, b_pc, b_inst, c_pc, c_inst;
  logic [1:0]  a_occ, b_occ, c_occ;
  logic [7:0]  a_cnt, b_cnt;
  logic [1:0]  c_cnt;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  if_id_pipe_stage #(.SKID(1), .NOP_INST(NOP)) a (.clk(clk), .rst(rst), .pcIn(pc_in), .instIn(inst_in),
    .in_valid(in_valid), .in_ready(a_ir), .flush(flush), .pcOut(a_pc), .instOut(a_inst),
    .out_valid(a_ov), .out_ready(out_ready), .occupancy(a_occ), .flush_cnt(a_cnt));
  if_id_pipe_stage #(.SKID(0), .NOP_INST(NOP)) b (.clk(clk), .rst(rst), .pcIn(pc_in), .instIn(inst_in),
    .in_valid(in_valid), .in_ready(b_ir), .flush(flush), .pcOut(b_pc), .instOut(b_inst),
    .out_valid(b_ov), .out_ready(out_ready), .occupancy(b_occ), .flush_cnt(b_cnt));
  if_id_pipe_stage #(.SKID(1), .NOP_INST(NOP), .CNT_W(2)) c (.clk(clk), .rst(rst), .pcIn(pc_in), .instIn(inst_in),
    .in_valid(in_valid), .in_ready(c_ir), .flush(flush), .pcOut(c_pc), .instOut(c_inst),
    .out_valid(c_ov), .out_ready(out_ready), .occupancy(c_occ), .flush_cnt(c_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("async_rst_ov", {63'b0, c_ov}, 64'd0);
    chk("async_rst_occ", {62'b0, c_occ}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1;
    tick();
    tick();
    chk("rst_ov", {63'b0, a_ov}, 64'd0);
    chk("rst_inst", {32'b0, a_inst}, {32'b0, NOP});
    chk("rst_pc", {32'b0, a_pc}, 64'd0);
    chk("rst_ir", {63'b0, a_ir}, 64'd1);
    chk("rst_cnt", {56'b0, a_cnt}, 64'd0);
    chk("rst_occ", {62'b0, a_occ}, 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    // streaming with no backpressure: one beat per cycle, one cycle latency
    for (int i = 0; i < 8; i++) begin
      pc_in = 32'(i * 4);
      inst_in = 32'h1000 + 32'(i);
      in_valid = 1'b1;
      chk("stream_ir", {63'b0, a_ir}, 64'd1);
      tick();
      chk("stream_ov", {63'b0, a_ov}, 64'd1);
      chk("stream_pc", {32'b0, a_pc}, 64'(i * 4));
      chk("stream_inst", {32'b0, a_inst}, 64'h1000 + 64'(i));
      chk("stream_b_pc", {32'b0, b_pc}, 64'(i * 4));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_ov", {63'b0, a_ov}, 64'd0);
    chk("drain_pc", {32'b0, a_pc}, 64'd0);
    chk("drain_inst", {32'b0, a_inst}, {32'b0, NOP});
    // backpressure fills the skid buffer
    out_ready = 1'b0;
    in_valid = 1'b1;
    pc_in = 32'h00; inst_in = 32'hA0;
    tick();
    pc_in = 32'h04; inst_in = 32'hA4;
    chk("bp_ir1", {63'b0, a_ir}, 64'd1);
    tick();
    pc_in = 32'h08; inst_in = 32'hA8;
    chk("bp_occ2", {62'b0, a_occ}, 64'd2);
    chk("bp_ir0", {63'b0, a_ir}, 64'd0);
    tick();
    chk("bp_hold_occ", {62'b0, a_occ}, 64'd2);
    chk("bp_hold_pc", {32'b0, a_pc}, 64'h00);
    chk("bp_hold_inst", {32'b0, a_inst}, 64'hA0);
    out_ready = 1'b1;
    #1;
    chk("bp_ir_registered", {63'b0, a_ir}, 64'd0);
    tick();
    chk("bp_pc2", {32'b0, a_pc}, 64'h04);
    chk("bp_occ1", {62'b0, a_occ}, 64'd1);
    chk("bp_ir_back", {63'b0, a_ir}, 64'd1);
    tick();
    chk("bp_pc3", {32'b0, a_pc}, 64'h08);
    chk("bp_inst3", {32'b0, a_inst}, 64'hA8);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {62'b0, a_occ}, 64'd0);
    // flush while holding two beats
    out_ready = 1'b0;
    in_valid = 1'b1;
    pc_in = 32'h20;
    tick();
    pc_in = 32'h24;
    tick();
    pc_in = 32'h28;
    flush = 1'b1;
    chk("fl2_ir", {63'b0, a_ir}, 64'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2_occ", {62'b0, a_occ}, 64'd0);
    chk("fl2_ov", {63'b0, a_ov}, 64'd0);
    chk("fl2_pc", {32'b0, a_pc}, 64'd0);
    chk("fl2_cnt", {56'b0, a_cnt}, 64'd2);
    // flush in ONE with a same-cycle accept and no issue
    in_valid = 1'b1;
    pc_in = 32'h30;
    tick();
    pc_in = 32'h34;
    flush = 1'b1;
    chk("fl1_ir", {63'b0, a_ir}, 64'd1);
    tick();
    flush = 1'b0;
    chk("fl1_cnt", {56'b0, a_cnt}, 64'd4);
    chk("fl1_occ", {62'b0, a_occ}, 64'd0);
    // flush while the held beat issues: nothing is lost
    out_ready = 1'b1;
    pc_in = 32'h40;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_iss_cnt", {56'b0, a_cnt}, 64'd4);
    chk("fl_iss_ov", {63'b0, a_ov}, 64'd0);
    // no-skid build: ready follows out_ready combinationally
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    pc_in = 32'h50; inst_in = 32'hB0;
    tick();
    chk("ns_ov", {63'b0, b_ov}, 64'd1);
    chk("ns_ir0", {63'b0, b_ir}, 64'd0);
    tick();
    chk("ns_occ1", {62'b0, b_occ}, 64'd1);
    chk("ns_hold_pc", {32'b0, b_pc}, 64'h50);
    pc_in = 32'h54; inst_in = 32'hB4;
    out_ready = 1'b1;
    #1;
    chk("ns_ir1", {63'b0, b_ir}, 64'd1);
    tick();
    chk("ns_reload_pc", {32'b0, b_pc}, 64'h54);
    chk("ns_reload_inst", {32'b0, b_inst}, 64'hB4);
    chk("ns_reload_occ", {62'b0, b_occ}, 64'd1);
    // narrow counter saturates instead of wrapping
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      pc_in = 32'h60 + 32'(k);
      tick();
      in_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("sat_cnt", {62'b0, c_cnt}, (k < 3) ? 64'(k) : 64'd3);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
